// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the core's MEM stage (master) and the memory
// responder (slave). Read data comes back combinationally in the same cycle.
interface data_mem_responder_if;
   logic [1:0]  mem_ctrl_input;   // bit1 = MemRead, bit0 = MemWrite
   logic [31:0] address;          // byte address
   logic [31:0] w_data;           // store data
   logic [31:0] read_data;        // load data, same cycle

   modport master (
      output mem_ctrl_input,
      output address,
      output w_data,
      input  read_data
   );

   modport slave (
      input  mem_ctrl_input,
      input  address,
      input  w_data,
      output read_data
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed RAM, a small MMIO window (output
// register, free-running cycle counter, error status), saturating access
// counters and sticky capture of the first faulting address.
module data_mem_responder #(
   parameter int unsigned DEPTH     = 256,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   data_mem_responder_if.slave  bus,
   output logic [31:0]          mmio_out,
   output logic                 err_flag,
   output logic [31:0]          err_addr,
   output logic [CNT_W-1:0]     rd_count,
   output logic [CNT_W-1:0]     wr_count
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
   localparam logic [7:0]  OFF_OUT   = 8'h00;
   localparam logic [7:0]  OFF_CYC   = 8'h04;
   localparam logic [7:0]  OFF_STAT  = 8'h08;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [31:0]      ram_q [DEPTH];
   logic [31:0]      out_q,   out_d;
   logic [31:0]      cyc_q,   cyc_d;
   logic             err_q,   err_d;
   logic [31:0]      eaddr_q, eaddr_d;
   logic [CNT_W-1:0] rdc_q,   rdc_d;
   logic [CNT_W-1:0] wrc_q,   wrc_d;

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic          is_rd, is_wr;
   logic          aligned;
   logic          ram_hit, mmio_hit, mmio_ok, mapped;
   logic          legal, err_req;
   logic [AW-1:0] idx;
   logic [7:0]    off;
   logic          ram_we;

   // Classify the current request; ctrl 11 is neither a read nor a write.
   always_comb begin
      is_rd    = (bus.mem_ctrl_input == 2'b10);
      is_wr    = (bus.mem_ctrl_input == 2'b01);
      aligned  = (bus.address[1:0] == 2'b00);
      ram_hit  = (bus.address < RAM_BYTES);
      mmio_hit = (bus.address[31:8] == MMIO_BASE[31:8]);
      off      = bus.address[7:0];
      idx      = bus.address[AW+1:2];
      mmio_ok  = mmio_hit && ((off == OFF_OUT) || (off == OFF_CYC) || (off == OFF_STAT));
      mapped   = ram_hit || mmio_ok;
      legal    = (is_rd || is_wr) && aligned && mapped;
      // Anything non-idle that is not legal is an error; stores are dropped.
      err_req  = (bus.mem_ctrl_input != 2'b00) && !legal;
      ram_we   = legal && is_wr && ram_hit;
   end

   // Same-cycle load data; forced to zero in reset, idle and error cases.
   always_comb begin
      bus.read_data = '0;
      if (reset_n && legal && is_rd) begin
         if (ram_hit) begin
            bus.read_data = ram_q[idx];
         end else begin
            unique case (off)
               OFF_OUT:  bus.read_data = out_q;
               OFF_CYC:  bus.read_data = cyc_q;
               OFF_STAT: bus.read_data = {31'b0, err_q};
               default:  bus.read_data = '0;
            endcase
         end
      end
   end

   // Next state for MMIO registers, error capture and counters.
   always_comb begin
      out_d   = out_q;
      cyc_d   = cyc_q + 32'd1;       // wraps naturally
      err_d   = err_q;
      eaddr_d = eaddr_q;
      rdc_d   = rdc_q;
      wrc_d   = wrc_q;

      if (legal && is_wr && mmio_ok && (off == OFF_OUT)) begin
         out_d = bus.w_data;
      end

      // A STATUS write clears the capture; it is legal, so it can never
      // coincide with an error request on this single-ported bus, but the
      // clear is written last so it would win regardless.
      if (err_req && !err_q) begin
         err_d   = 1'b1;
         eaddr_d = bus.address;
      end
      if (legal && is_wr && mmio_ok && (off == OFF_STAT)) begin
         err_d   = 1'b0;
         eaddr_d = '0;
      end

      if (legal && is_rd && (rdc_q != '1)) begin
         rdc_d = rdc_q + CNT_W'(1);
      end
      if (legal && is_wr && (wrc_q != '1)) begin
         wrc_d = wrc_q + CNT_W'(1);
      end
   end

   // RAM array; cleared asynchronously so a store in flight at reset is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            ram_q[i] <= '0;
         end
      end else if (ram_we) begin
         ram_q[idx] <= bus.w_data;
      end
   end

   // MMIO, error and counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q   <= '0;
         cyc_q   <= '0;
         err_q   <= 1'b0;
         eaddr_q <= '0;
         rdc_q   <= '0;
         wrc_q   <= '0;
      end else begin
         out_q   <= out_d;
         cyc_q   <= cyc_d;
         err_q   <= err_d;
         eaddr_q <= eaddr_d;
         rdc_q   <= rdc_d;
         wrc_q   <= wrc_d;
      end
   end

   assign mmio_out = out_q;
   assign err_flag = err_q;
   assign err_addr = eaddr_q;
   assign rd_count = rdc_q;
   assign wr_count = wrc_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed steps from the test plan plus a
// randomized run, all checked against a word-array reference model.
module tb_data_mem_responder;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic             clk;
   logic             reset_n;
   logic [31:0]      mmio_out;
   logic             err_flag;
   logic [31:0]      err_addr;
   logic [CNT_W-1:0] rd_count;
   logic [CNT_W-1:0] wr_count;

   data_mem_responder_if bus();

   data_mem_responder #(
      .DEPTH     (DEPTH),
      .MMIO_BASE (32'hFFFF_FF00),
      .CNT_W     (CNT_W)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .mmio_out (mmio_out),
      .err_flag (err_flag),
      .err_addr (err_addr),
      .rd_count (rd_count),
      .wr_count (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int misc = 0;

   // Reference model state
   logic [31:0] m_mem [0:DEPTH-1];
   logic [31:0] m_out, m_cyc, m_eaddr;
   bit          m_err;
   int          m_rdc, m_wrc;
   logic [31:0] rd_obs;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         misc++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
      m_out = '0; m_cyc = '0; m_eaddr = '0; m_err = 1'b0;
      m_rdc = 0; m_wrc = 0;
   endtask

   function automatic bit m_in_ram(input logic [31:0] a);
      return a < 32'(DEPTH * 4);
   endfunction

   function automatic bit m_legal(input logic [1:0] c, input logic [31:0] a);
      bit mmio;
      mmio = (a[31:8] == 24'hFF_FFFF) && (a[7:0] == 8'h00 || a[7:0] == 8'h04 || a[7:0] == 8'h08);
      return (c == 2'b10 || c == 2'b01) && (a[1:0] == 2'b00) && (m_in_ram(a) || mmio);
   endfunction

   function automatic logic [31:0] m_rdata(input logic [1:0] c, input logic [31:0] a);
      if (c != 2'b10 || !m_legal(c, a)) return '0;
      if (m_in_ram(a)) return m_mem[a[AW+1:2]];
      case (a[7:0])
         8'h00:   return m_out;
         8'h04:   return m_cyc;
         default: return {31'b0, m_err};
      endcase
   endfunction

   // Apply the rules of one clock edge to the model, using pre-edge values.
   task automatic model_edge(input logic [1:0] c, input logic [31:0] a, input logic [31:0] w);
      bit lg;
      lg = m_legal(c, a);
      if (lg && c == 2'b01) begin
         if (m_in_ram(a)) m_mem[a[AW+1:2]] = w;
         else if (a[7:0] == 8'h00) m_out = w;
         else if (a[7:0] == 8'h08) begin m_err = 1'b0; m_eaddr = '0; end
         if (m_wrc < 65535) m_wrc++;
      end
      if (lg && c == 2'b10 && m_rdc < 65535) m_rdc++;
      if (!lg && c != 2'b00 && !m_err) begin
         m_err = 1'b1; m_eaddr = a;
      end
      m_cyc = m_cyc + 32'd1;
   endtask

   task automatic chk_state();
      chk("mmio_out", mmio_out, m_out);
      chk("err_flag", 32'(err_flag), 32'(m_err));
      chk("err_addr", err_addr, m_eaddr);
      chk("rd_count", 32'(rd_count), 32'(m_rdc));
      chk("wr_count", 32'(wr_count), 32'(m_wrc));
   endtask

   // One bus cycle: drive after the falling edge, check load data mid-cycle,
   // then check registered state just after the rising edge.
   task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [31:0] w);
      bus.mem_ctrl_input = c;
      bus.address        = a;
      bus.w_data         = w;
      #1;
      rd_obs = bus.read_data;
      chk("read_data", rd_obs, m_rdata(c, a));
      @(posedge clk);
      model_edge(c, a, w);
      #1;
      chk_state();
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] r1, r2, a;
      logic [1:0]  c;
      int          t;

      bus.mem_ctrl_input = 2'b10;
      bus.address        = 32'h10;
      bus.w_data         = '0;
      reset_n            = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_read_data", bus.read_data, 32'h0);
      chk_state();
      bus.mem_ctrl_input = 2'b00;
      reset_n = 1'b1;
      @(negedge clk);
      // Cycle counter is one edge ahead of the model after the wait above.
      model_edge(2'b00, 32'h0, 32'h0);

      // Basic write then read-back
      step(2'b01, 32'h10, 32'hDEAD_BEEF);
      step(2'b10, 32'h10, 32'h0);
      chk("rd_deadbeef", rd_obs, 32'hDEAD_BEEF);
      chk("wr_cnt_1", 32'(wr_count), 32'd1);
      chk("rd_cnt_1", 32'(rd_count), 32'd1);

      // RAM top boundary, first unmapped word, then sticky err_addr
      step(2'b01, 32'h3FC, 32'h0BAD_F00D);
      step(2'b10, 32'h3FC, 32'h0);
      chk("top_word", rd_obs, 32'h0BAD_F00D);
      chk("top_noerr", 32'(err_flag), 32'd0);
      step(2'b10, 32'h400, 32'h0);
      chk("oob_rdata", rd_obs, 32'h0);
      chk("oob_eaddr", err_addr, 32'h400);
      step(2'b10, 32'h5, 32'h0);
      chk("sticky_eaddr", err_addr, 32'h400);

      // MMIO output register and cycle counter
      step(2'b01, 32'hFFFF_FF00, 32'h0000_00A5);
      chk("mmio_a5", mmio_out, 32'hA5);
      step(2'b10, 32'hFFFF_FF04, 32'h0);
      r1 = rd_obs;
      step(2'b10, 32'hFFFF_FF04, 32'h0);
      r2 = rd_obs;
      chk("cyc_delta", r2 - r1, 32'd1);
      step(2'b10, 32'hFFFF_FF08, 32'h0);
      chk("status_rd", rd_obs, 32'h1);

      // Clear, then ctrl 11 must not store and must flag
      step(2'b01, 32'hFFFF_FF08, 32'h0);
      step(2'b01, 32'h20, 32'h5555_5555);
      step(2'b11, 32'h20, 32'h1234);
      chk("c11_rdata", rd_obs, 32'h0);
      chk("c11_err", 32'(err_flag), 32'd1);
      chk("c11_eaddr", err_addr, 32'h20);
      step(2'b10, 32'h20, 32'h0);
      chk("c11_nostore", rd_obs, 32'h5555_5555);
      step(2'b01, 32'hFFFF_FF08, 32'hFFFF_FFFF);
      chk("clr_err", 32'(err_flag), 32'd0);
      chk("clr_eaddr", err_addr, 32'h0);

      // Randomized traffic across every decode region
      for (int n = 0; n < 400; n++) begin
         c = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 6))
            0, 1: a = {22'b0, 4'($urandom_range(0, 15)), 2'b00} + 32'h40;
            2:    a = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            3:    a = {22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            4: begin
               case ($urandom_range(0, 4))
                  0: a = 32'hFFFF_FF00;
                  1: a = 32'hFFFF_FF04;
                  2: a = 32'hFFFF_FF08;
                  3: a = 32'hFFFF_FF0C;
                  default: a = 32'hFFFF_FF02;
               endcase
            end
            5:    a = 32'h400 + $urandom_range(0, 4095);
            default: a = 32'h3FC;
         endcase
         step(c, a, $urandom);
      end

      // Read-counter saturation: 2^16 + 3 legal reads without per-cycle checks
      bus.mem_ctrl_input = 2'b10;
      bus.address        = 32'h0;
      bus.w_data         = '0;
      repeat (65539) @(posedge clk);
      t = m_rdc + 65539;
      m_rdc = (t > 65535) ? 65535 : t;
      m_cyc = m_cyc + 32'd65539;
      #1;
      chk("rd_sat", 32'(rd_count), 32'h0000_FFFF);
      chk_state();
      @(negedge clk);
      step(2'b10, 32'hFFFF_FF04, 32'h0);
      step(2'b10, 32'h0, 32'h0);
      chk("rd_sat_hold", 32'(rd_count), 32'h0000_FFFF);

      // Reset asserted in the middle of a store
      step(2'b01, 32'h40, 32'hCAFE_F00D);
      step(2'b01, 32'hFFFF_FF00, 32'h7777_7777);
      bus.mem_ctrl_input = 2'b01;
      bus.address        = 32'h40;
      bus.w_data         = 32'h1111_1111;
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_rdata", bus.read_data, 32'h0);
      chk_state();
      bus.mem_ctrl_input = 2'b00;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      model_edge(2'b00, 32'h0, 32'h0);
      step(2'b10, 32'h40, 32'h0);
      chk("ram16_clr", rd_obs, 32'h0);
      step(2'b10, 32'h10, 32'h0);
      chk("ram4_clr", rd_obs, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, misc);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's data-memory interface: accepts the MEM-stage control, address and write data, and returns read data in the same cycle.
- Contents: a word-addressed RAM, a small memory-mapped I/O window (output register, free-running cycle counter, status), access counters and sticky error capture.
- Instantiated beside the core in the system top and bench; drives the core's read_data input.

Parameters:
- DEPTH, 256, number of 32-bit RAM words (power of two, 16..4096).
- MMIO_BASE, 32'hFFFF_FF00, byte base of the MMIO window (256-byte aligned).
- CNT_W, 16, width of the read/write access counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- mem_ctrl_input  input  2  bit1 = MemRead, bit0 = MemWrite.
- address  input  32  byte address from the MEM stage.
- w_data  input  32  store data.
- read_data  output  32  load data, combinational in the same cycle as the request.
- mmio_out  output  32  MMIO output register.
- err_flag  output  1  sticky error.
- err_addr  output  32  address of the first error since last clear.
- rd_count  output  CNT_W  completed legal reads, saturating.
- wr_count  output  CNT_W  completed legal writes, saturating.

Behaviour:
- Reset (async assert, synchronous deassert-safe):
  - All RAM words = 0; mmio_out = 0; cycle counter = 0.
  - err_flag = 0; err_addr = 0; rd_count = wr_count = 0.
  - read_data = 0 while reset_n low.
- Address decode, per cycle:
  - RAM hit: address < DEPTH*4; word index = address[log2(DEPTH)+1:2].
  - MMIO hit: address[31:8] == MMIO_BASE[31:8]. Offsets: 0x00 OUT (R/W), 0x04 CYCLE (RO), 0x08 STATUS (R: {31'b0, err_flag}; any write clears error).
  - Otherwise, or any other MMIO offset: unmapped.
- Legal request: ctrl is 10 or 01, address[1:0] == 0, and the target is mapped.
- Error request: ctrl is 11, or misaligned, or unmapped, with ctrl != 00.
  - Store is suppressed; read_data = 0.
  - On the next edge, if err_flag is 0: err_flag <= 1 and err_addr <= address. Later errors do not overwrite err_addr.
- ctrl 00: idle. read_data = 0; no state change apart from the cycle counter.
- Read (ctrl 10): read_data = RAM[idx] or MMIO value, combinationally in the same cycle. rd_count += 1 at the edge.
- Write (ctrl 01): RAM/OUT updated at the rising edge. wr_count += 1 at the edge.
  - Write to CYCLE: legal, value ignored, counted.
  - Write to STATUS: clears err_flag and err_addr at the edge. If an error occurs in the same cycle, the clear wins (STATUS write is itself legal).
- Read-during-write ordering: a read in cycle N+1 returns the data written in cycle N. Within a single cycle no read/write mix is possible (ctrl 11 is an error).
- Cycle counter: +1 every clock after reset, wraps 32'hFFFF_FFFF -> 0. A read returns the pre-edge value.
- Access counters: saturate at all-ones; no wrap.
- Reset mid-operation: a store in flight at reset assertion is discarded; all state returns to reset values immediately.

Test Plan:
- Reset, then write 32'hDEAD_BEEF to 0x10 (ctrl 01), then next cycle read 0x10 (ctrl 10) -> read_data = 32'hDEAD_BEEF same cycle; wr_count = 1; rd_count = 1 after the edge.
- Read address 0x3FC then 0x400 with DEPTH=256 -> first returns stored/0 value with no error; second returns 0, err_flag = 1, err_addr = 32'h400. A subsequent misaligned read at 0x5 keeps err_addr = 32'h400.
- Write 32'h0000_00A5 to 0xFFFF_FF00 -> mmio_out = 32'hA5 after the edge. Read 0xFFFF_FF04 on two consecutive cycles -> values differ by exactly 1.
- ctrl 11 at address 0x20 with w_data 32'h1234 -> RAM[8] unchanged, read_data = 0, err_flag = 1. Then write 0xFFFF_FF08 -> err_flag = 0, err_addr = 0.
- Issue 2^CNT_W + 3 legal reads -> rd_count holds at 16'hFFFF.
- Assert reset_n low mid-burst, during a write to 0x40 -> RAM[16] = 0 and all outputs at reset values, without waiting for a clock edge.
